// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed program as a byte stream, assembles
// little-endian 32-bit words, writes them to instruction memory from word 0 and
// holds the core in reset until the whole frame has been taken.
//
// Frame: LEN_LO, LEN_HI (N = word count), then 4*N data bytes.
// Optional build macro BOOT_CHECKSUM_EN adds one trailing byte: the XOR of
// LEN_LO, LEN_HI and every data byte. On a match the core is released; on a
// mismatch the core stays in reset. Without the macro there is no CHK state.
//
// Handshake: a byte moves when rx_valid & rx_ready are both high on a rising
// clk edge. rx_ready is a registered decode of the FSM state; it is high in
// LEN_LO/LEN_HI/DATA/CHK and low in DONE/ERR. rx_valid may stay high while
// rx_ready is low, and then nothing is consumed.
//
// dbg_state exposes the FSM state encoding for checkers.
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              boot_done,
    output logic              boot_err,
    output logic [2:0]        dbg_state
);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CHK    = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;
`endif

    // Largest accepted word count: the full imem.
    localparam int unsigned CAP = 1 << ADDR_W;

    state_t            state_q;
    state_t            state_next;
    logic              transfer;
    logic [15:0]       n_new;
    logic              last_byte;
    logic              len_too_big;

    logic [7:0]        len_lo_q;
    logic [15:0]       words_left_q;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W-1:0] word_addr_q;
    logic [23:0]       word_buf_q;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        chk_q;
`endif

    assign dbg_state = state_q;

    // Next-state decode; the terminal states only leave on rst.
    always_comb begin
        state_next  = state_q;
        transfer    = rx_valid & rx_ready;
        n_new       = {rx_data, len_lo_q};
        len_too_big = 32'(n_new) > CAP;
        last_byte   = (byte_cnt_q == 2'd3) && (words_left_q == 16'd1);
        case (state_q)
            S_LEN_LO: begin
                if (transfer) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (transfer) begin
                    if (n_new == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_next = S_CHK;
`else
                        state_next = S_DONE;
`endif
                    end else if (len_too_big) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (transfer && last_byte) begin
`ifdef BOOT_CHECKSUM_EN
                    state_next = S_CHK;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CHK: begin
                if (transfer) state_next = (rx_data == chk_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_ERR;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_LEN_LO;
        else     state_q <= state_next;
    end

    // Status outputs registered from the next state so they change with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready  <= 1'b0;
            core_rst  <= 1'b1;
            boot_done <= 1'b0;
            boot_err  <= 1'b0;
        end else begin
            rx_ready  <= (state_next != S_DONE) && (state_next != S_ERR);
            core_rst  <= (state_next != S_DONE);
            boot_done <= (state_next == S_DONE);
            boot_err  <= (state_next == S_ERR);
        end
    end

    // Length capture, word assembly and the one-cycle imem write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            len_lo_q     <= 8'd0;
            words_left_q <= 16'd0;
            byte_cnt_q   <= 2'd0;
            word_addr_q  <= '0;
            word_buf_q   <= 24'd0;
        end else begin
            imem_we <= 1'b0;
            if (transfer) begin
                case (state_q)
                    S_LEN_LO: len_lo_q <= rx_data;
                    S_LEN_HI: begin
                        words_left_q <= n_new;
                        byte_cnt_q   <= 2'd0;
                        word_addr_q  <= '0;
                    end
                    S_DATA: begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: word_buf_q[7:0]   <= rx_data;
                            2'd1: word_buf_q[15:8]  <= rx_data;
                            2'd2: word_buf_q[23:16] <= rx_data;
                            default: begin
                                imem_we      <= 1'b1;
                                imem_addr    <= word_addr_q;
                                imem_wdata   <= {rx_data, word_buf_q};
                                word_addr_q  <= word_addr_q + 1'b1;
                                words_left_q <= words_left_q - 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running XOR over the length bytes and every data byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= 8'd0;
        end else if (transfer) begin
            if (state_q == S_LEN_LO)                         chk_q <= rx_data;
            else if (state_q == S_LEN_HI || state_q == S_DATA) chk_q <= chk_q ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed testbench for imem_boot_loader (ADDR_W = 8).
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              boot_done;
    logic              boot_err;
    logic [2:0]        dbg_state;

    int tests = 0;
    int fails = 0;

    // {addr, data} of every write the bench expects, in order.
    logic [39:0] exp_q[$];
    logic [7:0]  frm[$];

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .boot_done  (boot_done),
        .boot_err   (boot_err),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every imem write must match the head of exp_q.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {39'd0, imem_we}, 40'd0);
            end else begin
                check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks.
    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (rx_ready !== 1'b1 && n < 50);
        if (rx_ready !== 1'b1) check("rx_ready_timeout", {39'd0, rx_ready}, 40'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h5a;
    endtask

    task automatic send_frame(input int use_gaps);
        int gaps[11] = '{1, 0, 3, 2, 0, 1, 3, 0, 2, 1, 0};
        for (int i = 0; i < frm.size(); i++) begin
            send_byte(frm[i]);
            if (use_gaps != 0) begin
                rx_data = 8'hee;
                repeat (gaps[i % 11]) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic add_chk();
`ifdef BOOT_CHECKSUM_EN
        logic [7:0] c;
        c = 8'h00;
        foreach (frm[i]) c ^= frm[i];
        frm.push_back(c);
`endif
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        check(tag, 40'(exp_q.size()), 40'd0);
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check({tag, "_done"},  {39'd0, boot_done}, 40'd1);
        check({tag, "_crst"},  {39'd0, core_rst},  40'd0);
        check({tag, "_err"},   {39'd0, boot_err},  40'd0);
        check({tag, "_ready"}, {39'd0, rx_ready},  40'd0);
    endtask

    // Directed sequence and final report.
    initial begin
        logic [7:0] b;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // 1: reset values, then rx_ready after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_core_rst",  {39'd0, core_rst},  40'd1);
        check("rst_rx_ready",  {39'd0, rx_ready},  40'd0);
        check("rst_imem_we",   {39'd0, imem_we},   40'd0);
        check("rst_boot_done", {39'd0, boot_done}, 40'd0);
        check("rst_boot_err",  {39'd0, boot_err},  40'd0);
        check("rst_addr_data", {imem_addr, imem_wdata}, 40'd0);
        check("rst_state",     {37'd0, dbg_state}, 40'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rel_rx_ready",  {39'd0, rx_ready}, 40'd1);

        // 2: back-to-back stream, write one cycle after each 4th data byte.
        frm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        add_chk();
        exp_q.push_back({8'd0, 32'h00A00513});
        exp_q.push_back({8'd1, 32'h00B00593});
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        for (int i = 0; i < frm.size(); i++) begin
            rx_data = frm[i];
            @(negedge clk);
            check("b2b_ready", {39'd0, rx_ready}, 40'd1);
            if (i > 0) check("b2b_we_latency", {39'd0, imem_we}, {39'd0, (i - 1 == 5) || (i - 1 == 9)});
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        @(negedge clk);
        check("b2b_we_last", {39'd0, imem_we}, {39'd0, frm.size() == 10});
        check("b2b_done",    {39'd0, boot_done}, 40'd1);
        check("b2b_crst",    {39'd0, core_rst},  40'd0);
        check("b2b_ready_0", {39'd0, rx_ready},  40'd0);
        check("b2b_state",   {37'd0, dbg_state}, 40'd4);
        // rx_valid held high in DONE: nothing consumed, no writes.
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        repeat (4) @(posedge clk);
        #1 rx_valid = 1'b0;
        check("done_hold_addr", {imem_addr, imem_wdata}, {8'd1, 32'h00B00593});
        drain("b2b_drain");

        // 3: same stream with gaps and garbage data while invalid.
        do_reset();
        exp_q.push_back({8'd0, 32'h00A00513});
        exp_q.push_back({8'd1, 32'h00B00593});
        send_frame(1);
        check_done("gap");
        drain("gap_drain");

        // 4: LEN = 0x0101 exceeds capacity -> ERR, no writes.
        do_reset();
        frm = '{8'h01, 8'h01};
        send_frame(0);
        @(negedge clk);
        check("err_flag",  {39'd0, boot_err},  40'd1);
        check("err_ready", {39'd0, rx_ready},  40'd0);
        check("err_crst",  {39'd0, core_rst},  40'd1);
        check("err_done",  {39'd0, boot_done}, 40'd0);
        check("err_state", {37'd0, dbg_state}, 40'd5);
        rx_valid = 1'b1;
        rx_data  = 8'h13;
        repeat (8) @(posedge clk);
        #1 rx_valid = 1'b0;
        @(negedge clk);
        check("err_sticky", {39'd0, boot_err}, 40'd1);
        drain("err_drain");

        // N == 0: done right after LEN_HI, no writes.
        do_reset();
        frm = '{8'h00, 8'h00};
        add_chk();
        send_frame(0);
        check_done("zero");
        drain("zero_drain");

        // 5: rst after 6 data bytes, then a clean single-word frame.
        do_reset();
        exp_q.push_back({8'd0, 32'h00A00513});
        frm = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05};
        send_frame(0);
        drain("abort_first_word");
        do_reset();
        check("abort_done", {39'd0, boot_done}, 40'd0);
        check("abort_crst", {39'd0, core_rst},  40'd1);
        exp_q.push_back({8'd0, 32'hDEADBEEF});
        frm = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_chk();
        send_frame(0);
        check_done("restart");
        drain("restart_drain");

        // Boundary: N = 256 fills the whole imem.
        do_reset();
        frm = '{8'h00, 8'h01};
        for (int w = 0; w < 256; w++) begin
            logic [31:0] word;
            for (int k = 0; k < 4; k++) begin
                b = 8'((4 * w + k) * 3 + 1);
                word[8 * k +: 8] = b;
                frm.push_back(b);
            end
            exp_q.push_back({8'(w), word});
        end
        add_chk();
        send_frame(0);
        check_done("full");
        check("full_last_addr", {32'd0, imem_addr}, 40'hff);
        drain("full_drain");

`ifdef BOOT_CHECKSUM_EN
        // 6: checksum match and mismatch.
        do_reset();
        exp_q.push_back({8'd0, 32'hDEADBEEF});
        frm = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
        send_frame(0);
        check_done("chk_ok");
        drain("chk_ok_drain");
        do_reset();
        exp_q.push_back({8'd0, 32'hDEADBEEF});
        frm = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h24};
        send_frame(0);
        @(negedge clk);
        check("chk_bad_err",  {39'd0, boot_err},  40'd1);
        check("chk_bad_crst", {39'd0, core_rst},  40'd1);
        check("chk_bad_done", {39'd0, boot_done}, 40'd0);
        drain("chk_bad_drain");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
